muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width.
REQ-002 Parameter ITER, default 32 (equals WIDTH), iteration cycles per multiply/divide.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 op  input  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-007 a  input  WIDTH  multiplicand / dividend; captured at accepted start.
REQ-008 b  input  WIDTH  multiplier / divisor; captured at accepted start.
REQ-009 busy  output  1  operation in progress; pipeline stalls HI/LO readers while high.
REQ-010 done  output  1  one-cycle pulse; hi/lo valid and updated in this cycle.
REQ-011 div_by_zero  output  1  pulses with done when a DIV/DIVU had b==0.
REQ-012 hi  output  WIDTH  HI register: product upper half / remainder.
REQ-013 lo  output  WIDTH  LO register: product lower half / quotient.

Function
REQ-014 States: IDLE, MUL, DIV, DONE; the unit SHALL leave IDLE only on accepted start.
REQ-015 Accepted start (in IDLE or DONE) SHALL capture a, b, op and go to MUL (op[0]=0) or DIV (op[0]=1).
REQ-016 MUL SHALL perform radix-2 shift-add over ITER cycles; DIV SHALL perform restoring division over ITER cycles.
REQ-017 After the last iteration the unit SHALL enter DONE for exactly one cycle, assert done, and write hi/lo in that cycle; DONE with no start SHALL return to IDLE.
REQ-018 Latency: start accepted in cycle 0 SHALL give done in cycle ITER+1 (33 by default).
REQ-019 busy SHALL be high from cycle 1 through cycle ITER and low in IDLE and DONE.
REQ-020 start while busy SHALL be ignored, with no effect on operands or state.
REQ-021 Back-to-back: start in the DONE cycle SHALL be accepted, with no idle cycle.
REQ-022 hi/lo SHALL hold their previous values while busy; partial results never appear on the outputs.
REQ-023 DIV/DIVU with b==0: next cycle SHALL be DONE (no iterations); hi=a, lo=all-ones, div_by_zero=1 with done.
REQ-024 Multiply SHALL produce the full 2*WIDTH product with no truncation; {hi,lo} = a*b.

Reset
REQ-025 rst_n low at a rising edge SHALL force IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
REQ-026 Reset mid-operation SHALL abort it with no done pulse; the captured operands are discarded.

Configuration
REQ-027 Macro MULDIV_SIGNED_EN defined: MULT/DIV (op[1]=1) SHALL be two's-complement signed.
REQ-028 Signed operation SHALL use magnitudes and fix signs at DONE; quotient truncates toward zero; remainder takes the dividend's sign.
REQ-029 Macro MULDIV_SIGNED_EN absent: op[1] SHALL be ignored and every operation treated as unsigned, with no signed-correction logic.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the op encoding constants, the state enum typedef and the default WIDTH.
REQ-031 The block SHALL be a single module with no sub-module.
REQ-032 Sign pre- and post-correction SHALL be inline logic inside the `ifdef` region.

Verification
REQ-033 MULTU a=7, b=6 -> done at cycle 33; hi=0x00000000, lo=0x0000002A.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIVU a=100, b=7 -> lo=14, hi=2; then DIVU b=0 -> done at cycle 2 with div_by_zero=1, lo=0xFFFFFFFF, hi=a.
REQ-036 With MULDIV_SIGNED_EN: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 start pulse at cycle 10 of a running MULTU -> ignored; first result unchanged; busy unaffected.
REQ-038 rst_n low at cycle 15 of DIVU -> next cycle IDLE, hi=lo=0, no done pulse; new start then completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, state type and default width for the multiply/divide unit
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO result registers
// Optional macro MULDIV_SIGNED_EN: op[1]=1 selects two's-complement signed MULT/DIV.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    // acc: running product high half / partial remainder; qm: multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qm;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] qm_nx;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] dbz_hi;

`ifdef MULDIV_SIGNED_EN
    logic             sa;
    logic             sb;
    logic             neg_hi;
    logic             neg_lo;
    logic [2*WIDTH-1:0] prod;
`else
    logic             unused_op1;
    assign unused_op1 = op[1];
`endif

    always_comb begin
        ma = a;
        mb = b;
`ifdef MULDIV_SIGNED_EN
        sa = 1'b0;
        sb = 1'b0;
        if (op[1]) begin
            sa = a[WIDTH-1];
            sb = b[WIDTH-1];
            if (sa) ma = -a;
            if (sb) mb = -b;
        end
`endif
    end

    always_comb begin
        mul_sum  = {1'b0, acc} + (qm[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_sh   = {acc, qm[WIDTH-1]};
        div_diff = div_sh[WIDTH-1:0] - opb;
        div_ge   = (div_sh >= {1'b0, opb});
        if (state == ST_MUL) begin
            acc_nx = mul_sum[WIDTH:1];
            qm_nx  = {mul_sum[0], qm[WIDTH-1:1]};
        end else begin
            // remainder stays below the divisor, so the modulo-2^WIDTH difference is exact
            acc_nx = div_ge ? div_diff : div_sh[WIDTH-1:0];
            qm_nx  = {qm[WIDTH-2:0], div_ge};
        end
        res_hi = acc_nx;
        res_lo = qm_nx;
        dbz_hi = qm;
`ifdef MULDIV_SIGNED_EN
        prod = {acc_nx, qm_nx};
        if (state == ST_MUL) begin
            if (neg_lo) prod = -prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            if (neg_hi) res_hi = -acc_nx;
            if (neg_lo) res_lo = -qm_nx;
        end
        if (neg_hi) dbz_hi = -qm;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            qm          <= '0;
            opb         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_hi      <= 1'b0;
            neg_lo      <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        acc  <= '0;
                        if (op[0]) begin
                            state <= ST_DIV;
                            qm    <= ma;
                            opb   <= mb;
                        end else begin
                            state <= ST_MUL;
                            qm    <= mb;
                            opb   <= ma;
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_hi <= sa;
                        neg_lo <= sa ^ sb;
`endif
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (state == ST_DIV && opb == '0) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        hi          <= dbz_hi;
                        lo          <= '1;
                    end else begin
                        acc <= acc_nx;
                        qm  <= qm_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(ITER - 1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            hi    <= res_hi;
                            lo    <= res_lo;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge; start is raised immediately so a call in a DONE cycle is back-to-back.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input logic edbz, input int glitch);
        int cyc;
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 1;
        check({tag, "_busy_c1"}, {63'd0, busy}, 64'd1);
        check({tag, "_hold"}, {hi, lo}, {last_hi, last_lo});
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == glitch) begin
                start = 1'b1; op = OP_DIVU; a = 32'd5; b = 32'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (glitch > 0 && cyc == glitch + 1)
                check({tag, "_busy_glitch"}, {63'd0, busy}, 64'd1);
        end
        check({tag, "_latency"}, 64'(cyc), 64'(elat));
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        last_hi = 32'h0; last_lo = 32'h0;

        run_op("multu_7x6", OP_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A, 33, 1'b0, 0);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33, 1'b0, 0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0, 0);
        run_op("divu_by0", OP_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 2, 1'b1, 0);
        run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 33, 1'b0, 0);
        run_op("divu_5_9", OP_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, 33, 1'b0, 0);
`ifdef MULDIV_SIGNED_EN
        run_op("div_s", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 0);
        run_op("mult_s", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 1'b0, 0);
`else
        run_op("div_u", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 33, 1'b0, 0);
        run_op("mult_u", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1, 33, 1'b0, 0);
`endif
        run_op("multu_ignore", OP_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 33, 1'b0, 10);
        @(posedge clk); #1;
        check("ignore_idle_busy", {63'd0, busy}, 64'd0);
        check("ignore_idle_done", {63'd0, done}, 64'd0);
        check("ignore_idle_hi", {32'd0, hi}, 64'h1);

        op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        check("midrst_no_done", {63'd0, seen}, 64'd0);
        last_hi = 32'h0; last_lo = 32'h0;
        run_op("divu_after_rst", OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, 33, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
